// File: rtl/ex_mdu_if.sv
// ex_mdu_if -- bundle between the EX-stage issue logic and the multiply/divide
// unit.
//
// Signals:
//   start      issue qualifier for md_op, valid for one cycle
//   md_op      0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   rs_data    forwarded rs operand
//   rt_data    forwarded rt operand
//   cancel     (MDU_CANCEL_EN only) flush of an in-flight or issuing MD op
//   busy       multi-cycle operation in flight
//   hi, lo     architectural HI/LO registers
//   state_dbg  current FSM state (0 idle, 1 busy) for observation
//
// Handshake: an op is taken on a rising clk edge where start=1 and busy=0
// (and cancel=0 when present). There is no ready; the issuer must hold off
// while busy=1, and a start seen while busy is silently dropped.
//
// Modports: master = issuing side, slave = the unit itself.
interface ex_mdu_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        state_dbg;
`ifdef MDU_CANCEL_EN
  logic        cancel;

  modport master (output start, md_op, rs_data, rt_data, cancel,
                  input  busy, hi, lo, state_dbg);
  modport slave  (input  start, md_op, rs_data, rt_data, cancel,
                  output busy, hi, lo, state_dbg);
`else
  modport master (output start, md_op, rs_data, rt_data,
                  input  busy, hi, lo, state_dbg);
  modport slave  (input  start, md_op, rs_data, rt_data,
                  output busy, hi, lo, state_dbg);
`endif
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu -- EX-stage multiply/divide unit owning HI/LO.
//
// The result is computed combinationally at issue and parked in
// pending_hi/pending_lo; a down-counter then models the multi-cycle latency
// before the pending value is committed to HI/LO. All outputs are registered.
//
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous, active-high; aborts any in-flight op
//   md     ex_mdu_if.slave (start, md_op, rs_data, rt_data, busy, hi, lo,
//          state_dbg, and cancel when MDU_CANCEL_EN is defined)
//
// Parameters:
//   MULT_CYCLES  busy cycles after a mult/multu issue
//   DIV_CYCLES   busy cycles after a div/divu issue
//
// Optional feature macro: MDU_CANCEL_EN adds the cancel input. When absent,
// in-flight operations always commit.
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  ex_mdu_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   pending_hi;
  logic [31:0]   pending_lo;
  logic          busy_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          issue;
  logic          cancel_req;

`ifdef MDU_CANCEL_EN
  assign cancel_req = md.cancel;
`else
  assign cancel_req = 1'b0;
`endif

  // Cancel in IDLE also suppresses mthi/mtlo.
  assign issue = md.start && !cancel_req;

  // ---------------- arithmetic ----------------
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag, b_mag, b_mag_safe, bu_safe;
  logic [31:0] qs_mag, rs_mag;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic        div_zero;

  always_comb begin
    prod_s = $signed({{32{md.rs_data[31]}}, md.rs_data}) *
             $signed({{32{md.rt_data[31]}}, md.rt_data});
    prod_u = {32'd0, md.rs_data} * {32'd0, md.rt_data};

    div_zero = (md.rt_data == 32'd0);

    // Signed divide on magnitudes. -2^31 has magnitude 2^31 as an unsigned
    // value, so 0x80000000 / -1 falls out as 0x80000000 remainder 0.
    a_mag      = md.rs_data[31] ? (~md.rs_data + 32'd1) : md.rs_data;
    b_mag      = md.rt_data[31] ? (~md.rt_data + 32'd1) : md.rt_data;
    // Divide-by-zero results are discarded; the substitute divisor only
    // keeps the divider free of undefined values.
    b_mag_safe = div_zero ? 32'd1 : b_mag;
    bu_safe    = div_zero ? 32'd1 : md.rt_data;

    qs_mag = a_mag / b_mag_safe;
    rs_mag = a_mag % b_mag_safe;
    q_s    = (md.rs_data[31] ^ md.rt_data[31]) ? (~qs_mag + 32'd1) : qs_mag;
    r_s    = md.rs_data[31] ? (~rs_mag + 32'd1) : rs_mag;

    q_u = md.rs_data / bu_safe;
    r_u = md.rs_data % bu_safe;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pending_hi <= '0;
      pending_lo <= '0;
      busy_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            case (md.md_op)
              OP_MULT: begin
                {pending_hi, pending_lo} <= prod_s;
                cnt    <= CW'(MULT_CYCLES);
                busy_q <= 1'b1;
                state  <= S_BUSY;
              end
              OP_MULTU: begin
                {pending_hi, pending_lo} <= prod_u;
                cnt    <= CW'(MULT_CYCLES);
                busy_q <= 1'b1;
                state  <= S_BUSY;
              end
              OP_DIV: begin
                // Divide by zero re-commits the current HI/LO, which cannot
                // change while busy, so they read as untouched.
                pending_hi <= div_zero ? hi_q : r_s;
                pending_lo <= div_zero ? lo_q : q_s;
                cnt    <= CW'(DIV_CYCLES);
                busy_q <= 1'b1;
                state  <= S_BUSY;
              end
              OP_DIVU: begin
                pending_hi <= div_zero ? hi_q : r_u;
                pending_lo <= div_zero ? lo_q : q_u;
                cnt    <= CW'(DIV_CYCLES);
                busy_q <= 1'b1;
                state  <= S_BUSY;
              end
              OP_MTHI: hi_q <= md.rs_data;
              OP_MTLO: lo_q <= md.rs_data;
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          if (cancel_req) begin
            cnt        <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
            busy_q     <= 1'b0;
            state      <= S_IDLE;
          end else if (cnt == CW'(1)) begin
            hi_q   <= pending_hi;
            lo_q   <= pending_lo;
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign md.busy      = busy_q;
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
  assign md.state_dbg = state;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu -- directed bench for ex_mdu.
// Driver tasks push {busy_len, hi, lo} expectations into exp_q; a monitor on
// the falling clock edge pops and compares whenever busy drops or HI/LO move.
module tb_ex_mdu;

  logic clk;
  logic reset;
  ex_mdu_if ifc();

  ex_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (ifc.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // {expected busy length[7:0], hi[31:0], lo[31:0]}
  logic [71:0] exp_q[$];

  // ---------------- monitor / scoreboard ----------------
  logic        prev_busy = 1'b0;
  logic [31:0] prev_hi   = '0;
  logic [31:0] prev_lo   = '0;
  logic        rst_seen  = 1'b1;
  int          busy_len  = 0;

  always @(negedge clk) begin
    logic        ev;
    logic [71:0] e;
    if (reset || rst_seen) begin
      rst_seen  = reset;
      busy_len  = 0;
    end else begin
      if (ifc.busy) busy_len++;
      ev = (prev_busy && !ifc.busy) || ({ifc.hi, ifc.lo} != {prev_hi, prev_lo});
      if (ev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_update: busy=%0b hi=%h lo=%h, required no change",
                   ifc.busy, ifc.hi, ifc.lo);
        end else begin
          e = exp_q.pop_front();
          if (ifc.hi !== e[63:32] || ifc.lo !== e[31:0] || busy_len != int'(e[71:64])) begin
            n_miss++;
            $display("FAIL result: got hi=%h lo=%h busy_cycles=%0d, required hi=%h lo=%h busy_cycles=%0d",
                     ifc.hi, ifc.lo, busy_len, e[63:32], e[31:0], e[71:64]);
          end
        end
        if (!ifc.busy) busy_len = 0;
      end
    end
    prev_busy = ifc.busy;
    prev_hi   = ifc.hi;
    prev_lo   = ifc.lo;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one op for one cycle and queue its expected result.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int nb);
    ifc.start   = 1'b1;
    ifc.md_op   = op;
    ifc.rs_data = a;
    ifc.rt_data = b;
    exp_q.push_back({8'(nb), eh, el});
    step();
    ifc.start = 1'b0;
  endtask

  // Drive one op for one cycle with no expected effect.
  task automatic poke(input logic [2:0] op, input logic [31:0] a);
    ifc.start   = 1'b1;
    ifc.md_op   = op;
    ifc.rs_data = a;
    ifc.rt_data = 32'd3;
    step();
    ifc.start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (ifc.busy && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) begin
      n_vec++;
      n_miss++;
      $display("FAIL busy_timeout: busy=%0b after %0d cycles, required 0", ifc.busy, k);
    end
    step();
    step();
  endtask

  task automatic check_regs(input string name, input logic [31:0] eh, input logic [31:0] el);
    n_vec++;
    if (ifc.busy !== 1'b0 || ifc.hi !== eh || ifc.lo !== el) begin
      n_miss++;
      $display("FAIL %s: got busy=%0b hi=%h lo=%h, required busy=0 hi=%h lo=%h",
               name, ifc.busy, ifc.hi, ifc.lo, eh, el);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ifc.start   = 1'b0;
    ifc.md_op   = 3'd0;
    ifc.rs_data = '0;
    ifc.rt_data = '0;
`ifdef MDU_CANCEL_EN
    ifc.cancel  = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_regs("reset_state", 32'h0, 32'h0);

    issue(3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);  wait_idle();
    issue(3'd2, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5);  wait_idle();
    issue(3'd1, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 5);  wait_idle();
    issue(3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10); wait_idle();
    issue(3'd4, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10); wait_idle();
    issue(3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10); wait_idle();
    issue(3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10); wait_idle();
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10); wait_idle();

    // mthi then mtlo back to back: no busy, one register each edge.
    issue(3'd5, 32'h12345678, 32'h0, 32'h12345678, 32'h80000000, 0);
    issue(3'd6, 32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0);
    wait_idle();

    // md_op none/reserved with start: no effect.
    poke(3'd0, 32'h55555555);
    poke(3'd7, 32'h66666666);
    wait_idle();

    // mthi while busy is dropped; the mult still commits normally.
    issue(3'd1, 32'd7, 32'd6, 32'h00000000, 32'h0000002A, 5);
    step();
    poke(3'd5, 32'hDEADBEEF);
    wait_idle();

    // Reset in the 3rd busy cycle aborts the mult; nothing commits later.
    ifc.start   = 1'b1;
    ifc.md_op   = 3'd1;
    ifc.rs_data = 32'h00010000;
    ifc.rt_data = 32'h00010000;
    step();
    ifc.start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_regs("reset_mid_busy", 32'h0, 32'h0);
    repeat (10) step();
    check_regs("no_late_commit", 32'h0, 32'h0);

`ifdef MDU_CANCEL_EN
    issue(3'd5, 32'h11111111, 32'h0, 32'h11111111, 32'h00000000, 0);
    issue(3'd6, 32'h11111111, 32'h0, 32'h11111111, 32'h11111111, 0);
    wait_idle();
    // cancel in IDLE blocks an mthi.
    ifc.cancel = 1'b1;
    poke(3'd5, 32'h22222222);
    ifc.cancel = 1'b0;
    wait_idle();
    // div 100/7, cancel in the 4th busy cycle: busy for 4 cycles, no commit.
    issue(3'd3, 32'd100, 32'd7, 32'h11111111, 32'h11111111, 4);
    step();
    step();
    ifc.cancel = 1'b1;
    step();
    ifc.cancel = 1'b0;
    check_regs("cancel_busy", 32'h11111111, 32'h11111111);
    repeat (12) step();
    check_regs("cancel_no_commit", 32'h11111111, 32'h11111111);
`endif

    repeat (3) step();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL missing_updates: %0d expected results never observed, required 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded MD opcode and the forwarded rs/rt operand values of the instruction currently in EX.
- Owns the architectural HI/LO registers and models multi-cycle latency through a busy counter.
- The hazard unit stalls ID while start or busy is high and an MD instruction is in ID.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after a mult/multu start.
- DIV_CYCLES, 10, cycles busy stays high after a div/divu start.

Ports:
- clk  input  1  clock, all state on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  qualifies md_op for one cycle (EX-stage instruction valid, not flushed).
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- rs_data  input  32  forwarded rs value.
- rt_data  input  32  forwarded rt value.
- busy  output  1  multi-cycle operation in flight.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset, synchronous, overrides everything, including an in-flight operation:
  - busy=0, hi=0, lo=0.
  - Counter and pending result registers cleared.
- An operation is accepted only when start=1 and busy=0. If start=1 while busy=1, the request is ignored with no state change; the hazard unit guarantees this does not occur.
- FSM states:
  - IDLE:
    - Accepted mult/multu/div/divu: latch the result into pending_hi/pending_lo in the same edge, load the counter with N (MULT_CYCLES or DIV_CYCLES), go to BUSY.
    - Accepted mthi: hi<=rs_data at the next edge; stay IDLE.
    - Accepted mtlo: lo<=rs_data at the next edge; stay IDLE.
    - md_op 0 or 7: no effect.
  - BUSY: busy=1; the counter decrements each cycle. When the counter is 1: hi<=pending_hi, lo<=pending_lo, counter<=0, go to IDLE.
- Timing: start accepted in cycle T → busy=1 in cycles T+1..T+N → new hi/lo and busy=0 visible in cycle T+N+1. hi/lo hold their old values throughout BUSY.
- Arithmetic:
  - mult/multu: 64-bit product, signed or unsigned; {hi,lo}=product.
  - div/divu: lo=quotient, hi=remainder.
    - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
    - 0x80000000 div 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero (rt_data=0): busy timing unchanged; hi/lo keep their pre-operation values at commit.
- Outputs hi/lo/busy are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit), used for exception/flush of an in-flight MD op.
  - cancel=1 in BUSY: go to IDLE at the next edge with busy=0; hi/lo unchanged; pending result discarded.
  - cancel=1 in IDLE: blocks the acceptance of start that cycle, including mthi/mtlo.
  - reset has priority over cancel.
- Not defined: no cancel port; in-flight operations always commit.

Test Plan:
- mult: rs=0xFFFFFFFE (-2), rt=0x00000003, start 1 cycle → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu, same operands → hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
- div: rs=0xFFFFFFF9 (-7), rt=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu with rt=0 → after 10 busy cycles hi/lo unchanged.
- mthi rs=0x12345678, then mtlo rs=0x9ABCDEF0 on back-to-back cycles → hi/lo updated the following edges, busy never asserts. A mthi issued while busy is ignored.
- Start mult, assert reset in the 3rd busy cycle → next cycle busy=0, hi=lo=0; no late commit afterwards.
- (MDU_CANCEL_EN) div 100/7 after hi=lo=0x11111111, cancel in the 4th busy cycle → busy=0 next cycle, hi/lo remain 0x11111111.
